// File: rtl/tft_pkg.sv
// Shared constants and types for the TFT burst read engine.
// Holds the default geometry, the per-burst tag and the command FSM states.
package tft_pkg;

    localparam int BURST_LEN = 4;
    localparam int TFT_AW    = 24;
    localparam int TFT_DW    = 16;

    // Per-burst bookkeeping: a stale burst still drains, but its words are dropped.
    typedef struct packed {
        logic stale;
    } tag_t;

    typedef enum logic [0:0] {
        IDLE,
        ISSUE
    } cmd_state_t;

endpackage

// File: rtl/tft_tag_queue.sv
// Circular FIFO of burst tags, one entry per burst in flight.
// Its occupancy is the outstanding-burst count; a flush can mark every entry stale.
module tft_tag_queue
    import tft_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    input  logic mark_all_stale,
    output tag_t head,
    output logic empty,
    output logic full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    tag_t          mem_q [DEPTH];
    tag_t          mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        // Marking happens before the write so a freshly pushed tag keeps its own value.
        if (mark_all_stale) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i].stale = 1'b1;
            end
        end
        if (push) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: tag storage is not reset; entries are only meaningful while counted by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/tft_burst_reader.sv
// Burst read engine feeding the TFT pixel fetch stage: issues fixed-length
// SDRAM bursts, returns beats one cycle later, and drops data from pre-flush bursts.
module tft_burst_reader
    import tft_pkg::*;
#(
    parameter int BURST   = BURST_LEN,
    parameter int MAX_OUT = 2,
    parameter int AW      = TFT_AW,
    parameter int DW      = TFT_DW
) (
    input  logic          clkSYS,
    input  logic          reset,
    input  logic          flush,
    input  logic          req,
    input  logic [AW-1:0] addr,
    output logic          rdy,
    output logic          ifrdy,
    output logic [DW-1:0] data,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic          mem_valid,
    input  logic [DW-1:0] mem_data,
    output logic          err
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    cmd_state_t    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          pend_stale_q, pend_stale_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          ifrdy_q, ifrdy_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;

    logic          q_push, q_pop, q_empty, q_full;
    tag_t          q_push_tag, q_head;
    logic          beat_ok;

    tft_tag_queue #(
        .DEPTH (MAX_OUT)
    ) u_tag_queue (
        .clk            (clkSYS),
        .reset          (reset),
        .push           (q_push),
        .push_tag       (q_push_tag),
        .pop            (q_pop),
        .mark_all_stale (flush),
        .head           (q_head),
        .empty          (q_empty),
        .full           (q_full)
    );

    // Command side: a command once raised is held until acked, never withdrawn.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        pend_stale_d = pend_stale_q;
        rdy          = 1'b0;
        q_push       = 1'b0;
        q_push_tag   = '0;

        unique case (state_q)
            IDLE: begin
                // Queue full is exactly "outstanding == MAX_OUT".
                rdy = req & ~flush & ~q_full;
                if (rdy) begin
                    mem_addr_d   = addr;
                    mem_req_d    = 1'b1;
                    pend_stale_d = 1'b0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    pend_stale_d = 1'b1;
                end
                if (mem_ack) begin
                    mem_req_d        = 1'b0;
                    q_push           = 1'b1;
                    q_push_tag.stale = pend_stale_q | flush;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response side: beats with no burst in flight are a protocol error and ignored.
    always_comb begin
        beat_ok = mem_valid & ~q_empty;
        q_pop   = beat_ok & (beat_q == BW'(BURST - 1));
        beat_d  = beat_q;
        err_d   = err_q | (mem_valid & q_empty);
        ifrdy_d = beat_ok & ~q_head.stale & ~flush;
        data_d  = beat_ok ? mem_data : data_q;

        if (beat_ok) begin
            beat_d = q_pop ? '0 : beat_q + BW'(1);
        end
    end

    always_ff @(posedge clkSYS) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            pend_stale_q <= 1'b0;
            beat_q       <= '0;
            ifrdy_q      <= 1'b0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            pend_stale_q <= pend_stale_d;
            beat_q       <= beat_d;
            ifrdy_q      <= ifrdy_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign ifrdy    = ifrdy_q;
    assign data     = data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_tft_burst_reader.sv
// Scenario bench for tft_burst_reader: expected words are queued when beats are
// driven and matched (value and 1-cycle latency) whenever ifrdy is seen.
module tb_tft_burst_reader;
    import tft_pkg::*;

    localparam int AW = TFT_AW;
    localparam int DW = TFT_DW;

    logic          clkSYS = 1'b0;
    logic          reset;
    logic          flush;
    logic          req;
    logic [AW-1:0] addr;
    logic          rdy;
    logic          ifrdy;
    logic [DW-1:0] data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic          mem_valid;
    logic [DW-1:0] mem_data;
    logic          err;

    tft_burst_reader dut (
        .clkSYS    (clkSYS),
        .reset     (reset),
        .flush     (flush),
        .req       (req),
        .addr      (addr),
        .rdy       (rdy),
        .ifrdy     (ifrdy),
        .data      (data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .err       (err)
    );

    always #5 clkSYS = ~clkSYS;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clkSYS) cyc <= cyc + 1;

    // Every ifrdy pulse must match the oldest expected word, exactly on its due cycle.
    always @(negedge clkSYS) begin
        if (ifrdy === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ifrdy: ifrdy=1 data=%h at cycle %0d, no word expected", data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (data !== e.d || cyc !== e.due) begin
                    n_fail++;
                    $display("FAIL word: got data=%h at cycle %0d, want data=%h at cycle %0d", data, cyc, e.d, e.due);
                end
            end
        end
    end

    task automatic step();
        @(negedge clkSYS);
    endtask

    task automatic send_burst(input logic [DW-1:0] base, input logic [DW-1:0] inc, input bit keep);
        for (int i = 0; i < BURST_LEN; i++) begin
            mem_valid = 1'b1;
            mem_data  = base + inc * DW'(i);
            if (keep) sb.push_back('{due: cyc + 1, d: mem_data});
            step();
        end
        mem_valid = 1'b0;
        mem_data  = '0;
    endtask

    task automatic issue_cmd(input logic [AW-1:0] a, input int ack_delay, input string name);
        req  = 1'b1;
        addr = a;
        #1;
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_accept: rdy=%b, want 1", name, rdy);
        end
        step();
        #1;
        n_checks++;
        if (rdy !== 1'b0 || mem_req !== 1'b1 || mem_addr !== a) begin
            n_fail++;
            $display("FAIL %s_issue: rdy=%b mem_req=%b mem_addr=%h, want 0 1 %h", name, rdy, mem_req, mem_addr, a);
        end
        req  = 1'b0;
        addr = '0;
        for (int i = 0; i < ack_delay; i++) begin
            step();
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== a) begin
                n_fail++;
                $display("FAIL %s_hold: mem_req=%b mem_addr=%h, want 1 %h", name, mem_req, mem_addr, a);
            end
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_acked: mem_req=%b, want 0", name, mem_req);
        end
    endtask

    task automatic drain(input string name);
        repeat (3) step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d words never delivered, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_checks++;
        if (mem_req !== 1'b0 || mem_addr !== '0 || ifrdy !== 1'b0 || data !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: mem_req=%b mem_addr=%h ifrdy=%b data=%h err=%b, want all 0",
                     mem_req, mem_addr, ifrdy, data, err);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_burst();
        issue_cmd(24'hF00010, 3, "single");
        send_burst(16'h1111, 16'h1111, 1'b1);
        drain("single");
    endtask

    task automatic test_outstanding_limit();
        int pulses = 0;
        bit took;
        req  = 1'b1;
        addr = 24'h000100;
        for (int i = 0; i < 8; i++) begin
            mem_ack = mem_req;
            #1;
            took = (rdy === 1'b1);
            if (took) pulses++;
            step();
            if (took) addr = addr + AW'(BURST_LEN);
        end
        mem_ack = 1'b0;
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL limit_pulses: %0d accepts, want 2", pulses);
        end
        for (int i = 0; i < BURST_LEN; i++) begin
            mem_valid = 1'b1;
            mem_data  = 16'h5000 + DW'(i);
            sb.push_back('{due: cyc + 1, d: mem_data});
            #1;
            n_checks++;
            if (rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL limit_blocked: rdy=%b during beat %0d, want 0", rdy, i);
            end
            step();
        end
        mem_valid = 1'b0;
        #1;
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_third: rdy=%b after last beat, want 1", rdy);
        end
        step();
        req = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 24'h000108) begin
            n_fail++;
            $display("FAIL limit_third_addr: mem_req=%b mem_addr=%h, want 1 000108", mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        send_burst(16'h6000, 16'h0001, 1'b1);
        send_burst(16'h7000, 16'h0001, 1'b1);
        drain("limit");
    endtask

    task automatic test_flush_mid_flight();
        issue_cmd(24'h000200, 0, "fmf_a");
        issue_cmd(24'h000204, 0, "fmf_b");
        flush = 1'b1;
        repeat (5) step();
        flush = 1'b0;
        send_burst(16'hA000, 16'h0001, 1'b0);
        send_burst(16'hA100, 16'h0001, 1'b0);
        // Both slots must be free again once the stale bursts have drained.
        issue_cmd(24'h000208, 0, "fmf_c");
        issue_cmd(24'h00020C, 0, "fmf_d");
        send_burst(16'hA200, 16'h0003, 1'b1);
        send_burst(16'hA300, 16'h0005, 1'b1);
        drain("fmf");
    endtask

    task automatic test_flush_during_issue();
        req  = 1'b1;
        addr = 24'h000300;
        #1;
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL fdi_accept: rdy=%b, want 1", rdy);
        end
        step();
        req   = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) flush = 1'b0;
            step();
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 24'h000300) begin
                n_fail++;
                $display("FAIL fdi_hold: mem_req=%b mem_addr=%h, want 1 000300", mem_req, mem_addr);
            end
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        send_burst(16'hB000, 16'h0001, 1'b0);
        flush = 1'b1;
        req   = 1'b1;
        addr  = 24'h000304;
        #1;
        n_checks++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL fdi_flush_block: rdy=%b while flush, want 0", rdy);
        end
        step();
        flush = 1'b0;
        #1;
        n_checks++;
        if (rdy !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fdi_after_flush: rdy=%b mem_req=%b, want 1 0", rdy, mem_req);
        end
        step();
        req = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        send_burst(16'hC000, 16'h0101, 1'b1);
        drain("fdi");
    endtask

    task automatic test_ack_and_last_beat();
        issue_cmd(24'h000400, 0, "alb_a");
        req  = 1'b1;
        addr = 24'h000404;
        #1;
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL alb_b_accept: rdy=%b, want 1", rdy);
        end
        step();
        req = 1'b0;
        for (int i = 0; i < BURST_LEN; i++) begin
            mem_valid = 1'b1;
            mem_data  = 16'hD000 + DW'(i);
            sb.push_back('{due: cyc + 1, d: mem_data});
            if (i == BURST_LEN - 1) mem_ack = 1'b1;
            step();
        end
        mem_valid = 1'b0;
        mem_ack   = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL alb_b_acked: mem_req=%b, want 0", mem_req);
        end
        // One burst left in flight: exactly one more fits.
        issue_cmd(24'h000408, 0, "alb_c");
        req  = 1'b1;
        addr = 24'h00040C;
        #1;
        n_checks++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL alb_full: rdy=%b with two in flight, want 0", rdy);
        end
        req = 1'b0;
        step();
        send_burst(16'hE000, 16'h0011, 1'b1);
        send_burst(16'hF000, 16'h0022, 1'b1);
        drain("alb");
    endtask

    task automatic test_protocol_error();
        mem_valid = 1'b1;
        mem_data  = 16'hDEAD;
        step();
        mem_valid = 1'b0;
        n_checks++;
        if (err !== 1'b1 || ifrdy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_set: err=%b ifrdy=%b, want 1 0", err, ifrdy);
        end
        // The ignored beat must not shift burst framing.
        issue_cmd(24'h000500, 0, "err_burst");
        send_burst(16'h1234, 16'h0001, 1'b1);
        drain("err");
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (err !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b mem_req=%b after reset, want 0 0", err, mem_req);
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req       = 1'b0;
        addr      = '0;
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        mem_data  = '0;
        step();
        test_reset();
        test_single_burst();
        test_outstanding_limit();
        test_flush_mid_flight();
        test_flush_during_issue();
        test_ack_and_last_beat();
        test_protocol_error();
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
